// File: rtl/prog_seq_pkg.sv
// Shared types for the program sequencer: FSM states, the per-cycle
// action code, and the priority encoder that turns requests into an action.
package prog_seq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_RET    = 3'd1,
    OP_CALL   = 3'd2,
    OP_JUMP   = 3'd3,
    OP_BRANCH = 3'd4,
    OP_INC    = 3'd5
  } op_t;

  // Exactly one action per cycle; lower-priority requests are dropped.
  function automatic op_t decode_op(input logic stall, input logic ret,
                                    input logic call, input logic jump,
                                    input logic branch);
    op_t op;
    op = OP_INC;
    if (stall)       op = OP_HOLD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
    return op;
  endfunction

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// Return-address LIFO. Push and pop are expected to be mutually exclusive
// (the parent never asks for both); push on full and pop on empty are ignored.
// Entry contents are not reset, only the occupancy count.
module ret_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_count;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_wr_idx  = IW'(r_count);
  assign w_rd_idx  = IW'(r_count - DW'(1));
  assign full      = (r_count == DW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full && !pop;
  assign w_do_pop  = pop && !empty && !push;
  assign top       = r_mem[w_rd_idx];
  assign depth     = r_count;

  // Storage write: the new entry lands just above the current top.
  always_ff @(posedge Clock) begin
    if (w_do_push) r_mem[w_wr_idx] <= din;
  end

  // Occupancy counter.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)        r_count <= '0;
    else if (w_do_push) r_count <= r_count + DW'(1);
    else if (w_do_pop)  r_count <= r_count - DW'(1);
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program-counter sequencer driving the program ROM address. One action per
// cycle chosen by priority; stack misuse parks the block in FAULT until reset.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int p_size      = 6,
  parameter int stack_depth = 4
) (
  input  logic                               Clock,
  input  logic                               nReset,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               branch,
  input  logic [p_size-1:0]                  jump_addr,
  input  logic [p_size-1:0]                  branch_off,
  output logic [p_size-1:0]                  address,
  output logic [$clog2(stack_depth+1)-1:0]   depth,
  output logic                               stack_err
);

  state_t            r_state;
  state_t            w_state_next;
  logic [p_size-1:0] r_pc;
  logic [p_size-1:0] w_pc_next;
  logic [p_size-1:0] w_pc_inc;
  logic [p_size-1:0] w_stk_top;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic              w_push;
  logic              w_pop;
  op_t               w_op;

  assign w_op     = decode_op(stall, ret, call, jump, branch);
  assign w_pc_inc = r_pc + p_size'(1);

  ret_stack #(
    .WIDTH (p_size),
    .DEPTH (stack_depth)
  ) u_stack (
    .Clock  (Clock),
    .nReset (nReset),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_pc_inc),
    .top    (w_stk_top),
    .depth  (depth),
    .full   (w_stk_full),
    .empty  (w_stk_empty)
  );

  // State and PC registers.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= RUN;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state / next-PC selection; FAULT holds everything.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    if (r_state == RUN) begin
      case (w_op)
        OP_HOLD: ;
        OP_RET: begin
          if (w_stk_empty) begin
            w_state_next = FAULT;
          end else begin
            w_pop     = 1'b1;
            w_pc_next = w_stk_top;
          end
        end
        OP_CALL: begin
          if (w_stk_full) begin
            w_state_next = FAULT;
          end else begin
            w_push    = 1'b1;
            w_pc_next = jump_addr;
          end
        end
        OP_JUMP:   w_pc_next = jump_addr;
        // Same-width modular add equals add of the sign-extended offset.
        OP_BRANCH: w_pc_next = r_pc + branch_off;
        default:   w_pc_next = w_pc_inc;
      endcase
    end
  end

  assign address   = r_pc;
  assign stack_err = (r_state == FAULT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed vector table, async reset
// checks, and randomized traffic against a queue-based reference model.
module tb_prog_sequencer;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       stall, jump, call, ret, branch;
  logic [5:0] jump_addr, branch_off;
  logic [5:0] address;
  logic [2:0] depth;
  logic       stack_err;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_fault;

  typedef struct {
    bit st, rt, cl, jp, br;
    int ja, bo;
    int ea, ed;
    bit ee;
  } vec_t;
  vec_t vecs[$];

  prog_sequencer dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .stall      (stall),
    .jump       (jump),
    .call       (call),
    .ret        (ret),
    .branch     (branch),
    .jump_addr  (jump_addr),
    .branch_off (branch_off),
    .address    (address),
    .depth      (depth),
    .stack_err  (stack_err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input bit st, input bit rt, input bit cl, input bit jp,
                     input bit br, input int ja, input int bo,
                     input int ea, input int ed, input bit ee);
    vec_t v;
    v.st = st; v.rt = rt; v.cl = cl; v.jp = jp; v.br = br;
    v.ja = ja; v.bo = bo; v.ea = ea; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endtask

  // Drive one cycle of requests, clock it, sample 1 time unit after the edge.
  task automatic apply(input bit st, input bit rt, input bit cl, input bit jp,
                       input bit br, input int ja, input int bo);
    stall = st; ret = rt; call = cl; jump = jp; branch = br;
    jump_addr = 6'(ja); branch_off = 6'(bo);
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_fault = 0;
  endtask

  // Behaviour straight from the action rules, using a queue as the stack.
  task automatic model_step(input bit st, input bit rt, input bit cl,
                            input bit jp, input bit br, input int ja,
                            input int bo);
    int off;
    if (m_fault || st) return;
    if (rt) begin
      if (m_stk.size() == 0) m_fault = 1;
      else m_pc = m_stk.pop_back();
    end else if (cl) begin
      if (m_stk.size() == 4) m_fault = 1;
      else begin
        m_stk.push_back((m_pc + 1) % 64);
        m_pc = ja;
      end
    end else if (jp) begin
      m_pc = ja;
    end else if (br) begin
      off = (bo >= 32) ? bo - 64 : bo;
      m_pc = (m_pc + off + 64) % 64;
    end else begin
      m_pc = (m_pc + 1) % 64;
    end
  endtask

  // Assert reset mid-cycle, confirm it acts before any clock edge, release.
  task automatic pulse_reset();
    #2 nReset = 1'b0;
    #1;
    check("async_rst_addr", address, 0);
    check("async_rst_depth", depth, 0);
    check("async_rst_err", stack_err, 0);
    #1 nReset = 1'b1;
    model_reset();
  endtask

  initial begin
    nReset = 1'b0;
    stall = 0; ret = 0; call = 0; jump = 0; branch = 0;
    jump_addr = '0; branch_off = '0;

    // Directed table: st rt cl jp br ja bo -> addr depth err
    add(0,0,0,0,0, 0, 0,  1,0,0);
    add(0,0,0,0,0, 0, 0,  2,0,0);
    add(0,0,0,0,0, 0, 0,  3,0,0);
    add(0,0,0,1,0,40, 0, 40,0,0);
    add(0,0,0,0,0, 0, 0, 41,0,0);
    add(0,0,0,1,1,10, 5, 10,0,0);
    add(0,0,0,0,1, 0,62,  8,0,0);
    add(0,0,0,1,0,62, 0, 62,0,0);
    add(0,0,0,0,1, 0, 5,  3,0,0);
    add(0,0,0,1,0,63, 0, 63,0,0);
    add(1,0,0,0,0, 0, 0, 63,0,0);
    add(1,0,0,0,0, 0, 0, 63,0,0);
    add(1,0,0,0,0, 0, 0, 63,0,0);
    add(0,0,0,0,0, 0, 0,  0,0,0);
    add(0,0,0,1,0, 7, 0,  7,0,0);
    add(0,0,1,0,0,20, 0, 20,1,0);
    for (int a = 21; a <= 25; a++) add(0,0,0,0,0,0,0, a,1,0);
    add(0,1,0,0,0, 0, 0,  8,0,0);
    add(0,0,0,1,0,63, 0, 63,0,0);
    add(0,0,1,0,0, 1, 0,  1,1,0);
    add(0,0,1,0,0, 2, 0,  2,2,0);
    add(0,0,1,0,0, 3, 0,  3,3,0);
    add(0,0,1,0,0,10, 0, 10,4,0);
    add(0,1,0,0,0, 0, 0,  4,3,0);
    add(0,1,0,0,0, 0, 0,  3,2,0);
    add(0,1,0,0,0, 0, 0,  2,1,0);
    add(0,1,0,0,0, 0, 0,  0,0,0);
    add(0,0,1,0,0,30, 0, 30,1,0);
    add(0,1,1,0,0,50, 0,  1,0,0);
    add(1,1,0,0,0, 0, 0,  1,0,0);
    add(0,0,0,0,0, 0, 0,  2,0,0);
    add(0,0,1,0,0, 5, 0,  5,1,0);
    add(0,0,1,0,0, 6, 0,  6,2,0);
    add(0,0,1,0,0, 7, 0,  7,3,0);
    add(0,0,1,0,0, 8, 0,  8,4,0);
    add(1,0,1,0,0, 9, 0,  8,4,0);
    add(0,0,1,0,0, 9, 0,  8,4,1);
    add(0,0,0,1,0,20, 0,  8,4,1);
    add(0,1,0,0,0, 0, 0,  8,4,1);
    add(0,0,0,0,0, 0, 0,  8,4,1);

    // Reset state while held in reset.
    #1;
    check("reset_addr", address, 0);
    check("reset_depth", depth, 0);
    check("reset_err", stack_err, 0);
    @(posedge Clock);
    #1;
    pulse_reset();

    // Free-running increment with wrap.
    for (int k = 1; k <= 70; k++) begin
      apply(0,0,0,0,0,0,0);
      check("inc_addr", address, k % 64);
      check("inc_depth", depth, 0);
      check("inc_err", stack_err, 0);
    end
    $display("increment run: 70 cycles, last address %0d", address);

    pulse_reset();
    foreach (vecs[i]) begin
      apply(vecs[i].st, vecs[i].rt, vecs[i].cl, vecs[i].jp, vecs[i].br,
            vecs[i].ja, vecs[i].bo);
      $display("vec %0d: addr=%0d depth=%0d err=%0d", i, address, depth, stack_err);
      check($sformatf("vec%0d_addr", i), address, vecs[i].ea);
      check($sformatf("vec%0d_depth", i), depth, vecs[i].ed);
      check($sformatf("vec%0d_err", i), stack_err, int'(vecs[i].ee));
    end

    // Reset out of FAULT, then underflow from reset.
    pulse_reset();
    apply(0,1,0,0,0,0,0);
    check("uflow_addr", address, 0);
    check("uflow_err", stack_err, 1);
    apply(0,0,0,1,0,5,0);
    check("uflow_hold_addr", address, 0);
    check("uflow_hold_err", stack_err, 1);
    pulse_reset();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bit st, rt, cl, jp, br;
      int ja, bo;
      if (m_fault && ($urandom_range(0, 3) == 0)) pulse_reset();
      st = ($urandom_range(0, 99) < 10);
      rt = ($urandom_range(0, 99) < 15);
      cl = ($urandom_range(0, 99) < 20);
      jp = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 25);
      ja = int'($urandom_range(0, 63));
      bo = int'($urandom_range(0, 63));
      apply(st, rt, cl, jp, br, ja, bo);
      model_step(st, rt, cl, jp, br, ja, bo);
      check("rand_addr", address, m_pc);
      check("rand_depth", depth, m_stk.size());
      check("rand_err", stack_err, int'(m_fault));
    end
    $display("random run: 3000 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
